// File: rtl/rm_load_ctrl.sv
// rtl/rm_load_ctrl.sv - MEM-stage load controller: word read, big-endian lane select, sign/zero extend.
// Optional watchdog on mem_ack enabled by defining RM_TIMEOUT_EN.
module rm_load_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  output logic              req_ready,
  output logic              stall_req,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_err,
  output logic              bus_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic {IDLE, READ} state_t;

  state_t            state, state_nxt;
  logic [5:0]        op_q, op_nxt;
  logic [1:0]        off_q, off_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic              load_valid_nxt, addr_err_nxt;
  logic [DATA_W-1:0] load_data_nxt, fmt_data;
  logic              is_load, misaligned;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign req_ready = (state == IDLE);
  assign stall_req = (state != IDLE);
  assign mem_re    = (state == READ);

  assign is_load = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                   (opcode == OP_LBU) || (opcode == OP_LHU);
  assign misaligned = (((opcode == OP_LH) || (opcode == OP_LHU)) && addr[0]) ||
                      ((opcode == OP_LW) && (addr[1:0] != 2'b00));

  // Byte 0 lives in the most significant lane (big-endian memory).
  always_comb begin
    sel_byte = mem_rdata[31:24];
    case (off_q)
      2'd0: sel_byte = mem_rdata[31:24];
      2'd1: sel_byte = mem_rdata[23:16];
      2'd2: sel_byte = mem_rdata[15:8];
      2'd3: sel_byte = mem_rdata[7:0];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
  end

  always_comb begin
    fmt_data = mem_rdata;
    case (op_q)
      OP_LB:   fmt_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  fmt_data = {24'h0, sel_byte};
      OP_LH:   fmt_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  fmt_data = {16'h0, sel_half};
      default: fmt_data = mem_rdata;
    endcase
  end

`ifdef RM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             bus_err_nxt;
`else
  assign bus_err = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  always_comb begin
    state_nxt      = state;
    op_nxt         = op_q;
    off_nxt        = off_q;
    mem_addr_nxt   = mem_addr;
    load_valid_nxt = 1'b0;
    addr_err_nxt   = 1'b0;
    load_data_nxt  = load_data;
`ifdef RM_TIMEOUT_EN
    wait_cnt_nxt   = wait_cnt;
    bus_err_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef RM_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
        if (req_valid && is_load) begin
          if (misaligned) begin
            addr_err_nxt = 1'b1;
          end else begin
            state_nxt    = READ;
            op_nxt       = opcode;
            off_nxt      = addr[1:0];
            mem_addr_nxt = {addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      READ: begin
        if (mem_ack) begin
          load_data_nxt  = fmt_data;
          load_valid_nxt = 1'b1;
          state_nxt      = IDLE;
`ifdef RM_TIMEOUT_EN
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          bus_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_q       <= 6'h0;
      off_q      <= 2'b00;
      mem_addr   <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      addr_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      off_q      <= off_nxt;
      mem_addr   <= mem_addr_nxt;
      load_valid <= load_valid_nxt;
      load_data  <= load_data_nxt;
      addr_err   <= addr_err_nxt;
    end
  end

`ifdef RM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rm_load_ctrl.sv
// tb/tb_rm_load_ctrl.sv - scoreboard bench for rm_load_ctrl.
module tb_rm_load_ctrl;

  localparam logic [2:0] K_LOAD = 3'b100;
  localparam logic [2:0] K_ADDR = 3'b010;
  localparam logic [2:0] K_BUS  = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic        req_ready, stall_req, mem_re;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        load_valid;
  logic [31:0] load_data;
  logic        addr_err, bus_err;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] last_data = 32'h0;

  rm_load_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .opcode(opcode), .addr(addr),
    .req_ready(req_ready), .stall_req(stall_req), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .load_valid(load_valid), .load_data(load_data),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [5:0] op, input logic [1:0] off,
                                        input logic [31:0] w);
    logic [31:0] s;
    s = w << (8 * off);
    case (op)
      6'h20:   return {{24{s[31]}}, s[31:24]};
      6'h24:   return {24'h0, s[31:24]};
      6'h21:   return {{16{s[31]}}, s[31:16]};
      6'h25:   return {16'h0, s[31:16]};
      default: return w;
    endcase
  endfunction

  function automatic bit is_ld(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit bad_align(input logic [5:0] op, input logic [31:0] a);
    return ((op == 6'h21 || op == 6'h25) && a[0]) || (op == 6'h23 && a[1:0] != 2'b00);
  endfunction

  always @(negedge clk) begin
    if (rst && (load_valid || addr_err || bus_err)) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pulse", {29'h0, load_valid, addr_err, bus_err}, 32'h0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("pulse_kind", {29'h0, load_valid, addr_err, bus_err}, {29'h0, e.kind});
        chk("load_data", load_data, e.data);
      end
    end
  end

  // n_ack: number of mem_re cycles, ack driven on the last. hold keeps req_valid
  // asserted with (h_op, h_addr) after acceptance.
  task automatic do_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd,
                         input int n_ack, input bit hold, input logic [5:0] h_op,
                         input logic [31:0] h_addr);
    logic [31:0] exp;
    req_valid = 1'b1; opcode = op; addr = a;
    chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    if (hold) begin opcode = h_op; addr = h_addr; end
    else req_valid = 1'b0;
    if (!is_ld(op)) begin
      chk("nonload_mem_re", {31'h0, mem_re}, 32'h0);
      chk("nonload_stall", {31'h0, stall_req}, 32'h0);
    end else if (bad_align(op, a)) begin
      sb_q.push_back('{K_ADDR, last_data});
      chk("adel_pulse", {31'h0, addr_err}, 32'h1);
      chk("adel_mem_re", {31'h0, mem_re}, 32'h0);
      @(posedge clk); #1;
      chk("adel_one_cycle", {31'h0, addr_err}, 32'h0);
      chk("adel_mem_re2", {31'h0, mem_re}, 32'h0);
    end else begin
      exp = model(op, a[1:0], rd);
      sb_q.push_back('{K_LOAD, exp});
      last_data = exp;
      for (int i = 1; i <= n_ack; i++) begin
        chk("mem_re", {31'h0, mem_re}, 32'h1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        chk("stall_busy", {31'h0, stall_req}, 32'h1);
        chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
        mem_rdata = (i == n_ack) ? rd : $urandom;
        mem_ack = (i == n_ack);
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
      chk("load_valid_lat", {31'h0, load_valid}, 32'h1);
      chk("mem_re_done", {31'h0, mem_re}, 32'h0);
      chk("stall_done", {31'h0, stall_req}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; opcode = 6'h0; addr = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_errs", {30'h0, addr_err, bus_err}, 32'h0);
    chk("rst_stall", {31'h0, stall_req}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_load(6'h24, 32'h1001, 32'h11A2B3C4, 1, 0, 6'h0, 32'h0);
    chk("lbu_value", load_data, 32'h000000A2);
    do_load(6'h20, 32'h1003, 32'h000000F0, 1, 0, 6'h0, 32'h0);
    chk("lb_value", load_data, 32'hFFFFFFF0);
    do_load(6'h21, 32'h1002, 32'h00008001, 2, 0, 6'h0, 32'h0);
    chk("lh_value", load_data, 32'hFFFF8001);
    do_load(6'h25, 32'h1002, 32'h00008001, 1, 0, 6'h0, 32'h0);
    chk("lhu_value", load_data, 32'h00008001);
    do_load(6'h23, 32'h2002, 32'h0, 1, 0, 6'h0, 32'h0);
    do_load(6'h21, 32'h2001, 32'h0, 1, 0, 6'h0, 32'h0);
    chk("adel_keeps_data", load_data, 32'h00008001);
    do_load(6'h2B, 32'h2000, 32'h0, 1, 0, 6'h0, 32'h0);

    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {31'h0, load_valid}, 32'h0);

    do_load(6'h23, 32'h3000, 32'hDEADBEEF, 5, 1, 6'h24, 32'h3005);
    chk("lw_value", load_data, 32'hDEADBEEF);
    do_load(6'h24, 32'h3005, 32'h00AB0000, 1, 0, 6'h0, 32'h0);
    chk("held_req_value", load_data, 32'h000000AB);

    for (int n = 0; n < 20; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 4))
        0: op = 6'h20;
        1: op = 6'h21;
        2: op = 6'h23;
        3: op = 6'h24;
        default: op = 6'h25;
      endcase
      do_load(op, $urandom, $urandom, $urandom_range(1, 3), 0, 6'h0, 32'h0);
    end

    do_load(6'h23, 32'h0000ABC4, 32'h55AA55AA, 1, 0, 6'h0, 32'h0);
    req_valid = 1'b1; opcode = 6'h23; addr = 32'h4000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_mem_re", {31'h0, mem_re}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("arst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("arst_mem_addr", mem_addr, 32'h0);
    chk("arst_stall", {31'h0, stall_req}, 32'h0);
    chk("arst_load_data", load_data, 32'h0);
    chk("arst_pulses", {29'h0, load_valid, addr_err, bus_err}, 32'h0);
    last_data = 32'h0;
    @(posedge clk); #2;
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("abort_no_valid", {31'h0, load_valid}, 32'h0);
    chk("abort_mem_re", {31'h0, mem_re}, 32'h0);
    chk("abort_data", load_data, 32'h0);

`ifdef RM_TIMEOUT_EN
    begin
      int re_cycles;
      re_cycles = 0;
      req_valid = 1'b1; opcode = 6'h23; addr = 32'h5000;
      sb_q.push_back('{K_BUS, last_data});
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (bus_err) break;
        if (mem_re) re_cycles++;
        @(posedge clk); #1;
      end
      chk("timeout_cycles", re_cycles, 32'd16);
      chk("timeout_bus_err", {31'h0, bus_err}, 32'h1);
      chk("timeout_no_valid", {31'h0, load_valid}, 32'h0);
      chk("timeout_mem_re", {31'h0, mem_re}, 32'h0);
      @(posedge clk); #1;
      chk("timeout_idle", {30'h0, stall_req, bus_err}, 32'h0);
      do_load(6'h23, 32'h5004, 32'hCAFEF00D, 16, 0, 6'h0, 32'h0);
      chk("ack_at_limit_no_bus_err", {31'h0, bus_err}, 32'h0);
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
